// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI slave front end
package spi_pkg;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } spi_state_t;

endpackage

// File: rtl/spi_if.sv
// rtl/spi_if.sv - SPI pin and RAM command/read-data bundle
interface spi_if;
    import spi_pkg::*;

    logic               SS_n;
    logic               MOSI;
    logic               MISO;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_piso.sv
// rtl/spi_piso.sv - read-byte load/shift-out register, MSB first, registered output bit
module spi_piso
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              bit_o,
    output logic              active_o,
    output logic              done_o,
    output logic              last_o
);

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              active_q, active_d;
    logic              done_q, done_d;
    logic              bit_q, bit_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q  <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            bit_q    <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            done_q   <= done_d;
            bit_q    <= bit_d;
        end
    end

    // last_o flags the edge on which the final bit reaches the output register
    assign last_o = active_q && (cnt_q == 4'd1);

    always_comb begin
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        done_d   = done_q;
        bit_d    = 1'b0;
        if (clr_i) begin
            shreg_d  = '0;
            cnt_d    = '0;
            active_d = 1'b0;
            done_d   = 1'b0;
        end else if (load_i) begin
            shreg_d  = data_i;
            cnt_d    = 4'(DATA_W);
            active_d = 1'b1;
            done_d   = 1'b0;
        end else if (active_q) begin
            bit_d   = shreg_q[DATA_W-1];
            shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
            cnt_d   = cnt_q - 4'd1;
            if (last_o) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end
        end
    end

    assign bit_o    = bit_q;
    assign active_o = active_q;
    assign done_o   = done_q;

endmodule

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI slave: MOSI frame deserialiser and MISO read-byte serialiser
module spi_slave_if
    import spi_pkg::*;
(
    input  logic clk,
    input  logic rst,
    spi_if.slave bus
);

    spi_state_t         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [FRAME_W-2:0] shift_q, shift_d;
    logic [FRAME_W-1:0] rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rd_addr_seen_q, rd_addr_seen_d;

    logic piso_clr, piso_load, piso_bit, piso_active, piso_done, piso_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_seen_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shift_q        <= shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_seen_q <= rd_addr_seen_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        shift_d        = shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_seen_d = rd_addr_seen_q;
        piso_clr       = 1'b0;
        piso_load      = 1'b0;
        if (bus.SS_n) begin
            state_d  = IDLE;
            cnt_d    = '0;
            shift_d  = '0;
            piso_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: state_d = CHK_CMD;
                CHK_CMD: begin
                    shift_d = {{(FRAME_W-2){1'b0}}, bus.MOSI};
                    cnt_d   = '0;
                    if (!bus.MOSI)          state_d = WRITE;
                    else if (rd_addr_seen_q) state_d = READ_DATA;
                    else                     state_d = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    // cnt_q == FRAME_W-1 marks a completed frame; later MOSI bits are ignored
                    if (cnt_q != 4'(FRAME_W - 1)) begin
                        shift_d = {shift_q[FRAME_W-3:0], bus.MOSI};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'(FRAME_W - 2)) begin
                            rx_data_d  = {shift_q, bus.MOSI};
                            rx_valid_d = 1'b1;
                            if (state_q == READ_ADD) rd_addr_seen_d = 1'b1;
                        end
                    end else if (state_q == READ_DATA) begin
                        if (!piso_active && !piso_done && bus.tx_valid) piso_load = 1'b1;
                        if (piso_last) rd_addr_seen_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    spi_piso u_piso (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (piso_clr),
        .load_i   (piso_load),
        .data_i   (bus.tx_data),
        .bit_o    (piso_bit),
        .active_o (piso_active),
        .done_o   (piso_done),
        .last_o   (piso_last)
    );

    assign bus.MISO     = piso_bit;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

endmodule
